// File: rtl/instruction_queue_pkg.sv
// Shared fetch/decode pipeline definitions used by the instruction queue
// and the fetch stage.
package instruction_queue_pkg;

  localparam int INS_W    = 32;
  localparam int IQ_DEPTH = 8;

  typedef struct packed {
    logic [INS_W-1:0] insA;
    logic [INS_W-1:0] insB;
    logic             dual;
  } fetch_pair_t;

endpackage

// File: rtl/instruction_queue_ram.sv
// DEPTH x INS_W register array for the instruction queue: two write ports,
// two asynchronous read ports, synchronous clear on reset.
module iq_ram
  import instruction_queue_pkg::*;
#(
  parameter int DEPTH = IQ_DEPTH,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             we0,
  input  logic [PTR_W-1:0] wa0,
  input  logic [INS_W-1:0] wd0,
  input  logic             we1,
  input  logic [PTR_W-1:0] wa1,
  input  logic [INS_W-1:0] wd1,
  input  logic [PTR_W-1:0] ra0,
  input  logic [PTR_W-1:0] ra1,
  output logic [INS_W-1:0] rd0,
  output logic [INS_W-1:0] rd1
);

  logic [INS_W-1:0] mem_q [DEPTH];
  logic [INS_W-1:0] mem_d [DEPTH];

  // The controller never drives both ports to the same address in one cycle.
  always_comb begin
    mem_d = mem_q;
    if (we0) mem_d[wa0] = wd0;
    if (we1) mem_d[wa1] = wd1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rd0 = mem_q[ra0];
  assign rd1 = mem_q[ra1];

endmodule

// File: rtl/instruction_queue.sv
// Circular dual-issue instruction queue between fetch and decode: accepts
// one or two instructions per cycle, releases them in pairs.
module instruction_queue
  import instruction_queue_pkg::*;
#(
  parameter  int DEPTH = IQ_DEPTH,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic             pushDual,
  input  logic [INS_W-1:0] pushInsA,
  input  logic [INS_W-1:0] pushInsB,
  output logic             full,
  input  logic             pop,
  output logic             queueEmpty,
  output logic [INS_W-1:0] insA,
  output logic [INS_W-1:0] insB,
  output logic [PTR_W:0]   count
);

  localparam logic [PTR_W:0] FULL_THR = (PTR_W+1)'(DEPTH - 2);
  localparam logic [PTR_W:0] PAIR_THR = (PTR_W+1)'(2);

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W:0]   cnt_q,  cnt_d;

  fetch_pair_t      fetch_in;
  logic             push_ok;
  logic             pop_ok;
  logic [PTR_W:0]   push_n;
  logic [PTR_W:0]   pop_n;

  always_comb begin
    fetch_in.insA = pushInsA;
    fetch_in.insB = pushInsB;
    fetch_in.dual = pushDual;
  end

  assign full       = (cnt_q > FULL_THR);
  assign queueEmpty = (cnt_q < PAIR_THR);
  assign count      = cnt_q;

  // A flush wins over any same-cycle traffic, including the storage writes.
  assign push_ok = push & ~full & ~flush;
  assign pop_ok  = pop & ~queueEmpty & ~flush;

  always_comb begin
    push_n = '0;
    if (push_ok) push_n = fetch_in.dual ? (PTR_W+1)'(2) : (PTR_W+1)'(1);
    pop_n = pop_ok ? (PTR_W+1)'(2) : '0;
  end

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    if (flush) begin
      head_d = '0;
      tail_d = '0;
      cnt_d  = '0;
    end else begin
      tail_d = tail_q + push_n[PTR_W-1:0];
      head_d = head_q + pop_n[PTR_W-1:0];
      cnt_d  = cnt_q + push_n - pop_n;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  iq_ram #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_ram (
    .clock (clock),
    .reset (reset),
    .we0   (push_ok),
    .wa0   (tail_q),
    .wd0   (fetch_in.insA),
    .we1   (push_ok & fetch_in.dual),
    .wa1   (tail_q + PTR_W'(1)),
    .wd1   (fetch_in.insB),
    .ra0   (head_q),
    .ra1   (head_q + PTR_W'(1)),
    .rd0   (insA),
    .rd1   (insB)
  );

endmodule

// File: tb/tb_instruction_queue.sv
// Scoreboard bench for instruction_queue: a reference queue tracks every
// accepted instruction and is compared against the DUT after each cycle.
module tb_instruction_queue;

  localparam int DEPTH = 8;
  localparam int PTR_W = $clog2(DEPTH);

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              flush = 1'b0;
  logic              push = 1'b0;
  logic              pushDual = 1'b0;
  logic [31:0]       pushInsA = '0;
  logic [31:0]       pushInsB = '0;
  logic              full;
  logic              pop = 1'b0;
  logic              queueEmpty;
  logic [31:0]       insA;
  logic [31:0]       insB;
  logic [PTR_W:0]    count;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] model_q [$];

  instruction_queue #(.DEPTH(DEPTH)) dut (
    .clock      (clock),
    .reset      (reset),
    .flush      (flush),
    .push       (push),
    .pushDual   (pushDual),
    .pushInsA   (pushInsA),
    .pushInsB   (pushInsB),
    .full       (full),
    .pop        (pop),
    .queueEmpty (queueEmpty),
    .insA       (insA),
    .insB       (insB),
    .count      (count)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h @%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_state(input string tag);
    int sz;
    sz = model_q.size();
    check_eq({tag, ".count"}, 32'(count), 32'(sz));
    check_eq({tag, ".empty"}, 32'(queueEmpty), 32'(sz < 2));
    check_eq({tag, ".full"}, 32'(full), 32'(sz > DEPTH - 2));
    if (sz >= 2) begin
      check_eq({tag, ".insA"}, insA, model_q[0]);
      check_eq({tag, ".insB"}, insB, model_q[1]);
    end
  endtask

  // Drive one cycle at the falling edge, update the model at the rising
  // edge, then compare at the next falling edge.
  task automatic cyc(input string tag, input logic f, input logic p, input logic d,
                     input logic [31:0] a, input logic [31:0] b, input logic po);
    bit pa, pk;
    flush = f; push = p; pushDual = d; pushInsA = a; pushInsB = b; pop = po;
    pa = p && (model_q.size() <= DEPTH - 2);
    pk = po && (model_q.size() >= 2);
    @(posedge clock);
    if (f) begin
      model_q.delete();
    end else begin
      if (pk) begin
        void'(model_q.pop_front());
        void'(model_q.pop_front());
      end
      if (pa) begin
        model_q.push_back(a);
        if (d) model_q.push_back(b);
      end
    end
    @(negedge clock);
    flush = 0; push = 0; pushDual = 0; pop = 0;
    check_state(tag);
  endtask

  initial begin
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    check_state("reset");
    check_eq("reset.insA", insA, 32'h0);
    check_eq("reset.insB", insB, 32'h0);

    cyc("idle_pop", 0, 0, 0, 0, 0, 1);
    cyc("dual_push", 0, 1, 1, 32'hAAAA0001, 32'hAAAA0002, 0);
    check_eq("dual_push.insA_lit", insA, 32'hAAAA0001);
    check_eq("dual_push.insB_lit", insB, 32'hAAAA0002);
    cyc("dual_pop", 0, 0, 0, 0, 0, 1);

    cyc("single1", 0, 1, 0, 32'h11, 32'hDEAD, 0);
    cyc("single1_pop", 0, 0, 0, 0, 0, 1);
    cyc("single2", 0, 1, 0, 32'h22, 32'hBEEF, 0);
    check_eq("single2.insA_lit", insA, 32'h11);
    check_eq("single2.insB_lit", insB, 32'h22);
    cyc("drain", 0, 0, 0, 0, 0, 1);

    for (int i = 0; i < 4; i++)
      cyc("fill", 0, 1, 1, 32'hF000_0000 + 32'(2*i), 32'hF000_0001 + 32'(2*i), 0);
    check_eq("fill.full_lit", 32'(full), 32'h1);
    cyc("push_full", 0, 1, 1, 32'hBAD0_0001, 32'hBAD0_0002, 0);
    cyc("push_full_single", 0, 1, 0, 32'hBAD0_0003, 32'h0, 0);
    cyc("pop1", 0, 0, 0, 0, 0, 1);
    cyc("pop2", 0, 0, 0, 0, 0, 1);
    cyc("wrap1", 0, 1, 1, 32'hC000_0000, 32'hC000_0001, 0);
    cyc("wrap2", 0, 1, 1, 32'hC000_0002, 32'hC000_0003, 0);
    for (int i = 0; i < 4; i++) cyc("wrap_drain", 0, 0, 0, 0, 0, 1);

    cyc("sim_pre", 0, 1, 1, 32'h5000_0001, 32'h5000_0002, 0);
    cyc("sim_pushpop", 0, 1, 1, 32'h5000_0003, 32'h5000_0004, 1);
    check_eq("sim.insA_lit", insA, 32'h5000_0003);
    check_eq("sim.insB_lit", insB, 32'h5000_0004);

    cyc("to6a", 0, 1, 1, 32'h6000_0001, 32'h6000_0002, 0);
    cyc("to6b", 0, 1, 1, 32'h6000_0003, 32'h6000_0004, 0);
    check_eq("to6.count_lit", 32'(count), 32'd6);
    cyc("flush", 1, 1, 1, 32'h7000_0001, 32'h7000_0002, 1);
    cyc("post_flush1", 0, 1, 0, 32'h33, 32'h0, 0);
    cyc("post_flush2", 0, 1, 0, 32'h44, 32'h0, 0);
    check_eq("post_flush.insA_lit", insA, 32'h33);

    for (int i = 0; i < 300; i++)
      cyc("rand", ($urandom_range(0, 31) == 0), $urandom_range(0, 1) == 1,
          $urandom_range(0, 1) == 1, $urandom, $urandom, $urandom_range(0, 2) == 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instruction_queue.md
Name: instruction_queue

Overview:
- Circular instruction buffer between the fetch stage (producer) and the decode stage (consumer).
- Fetch pushes one or two 32-bit instructions per cycle. Decode sees the two oldest entries as a dual-issue pair and pops both with a single `pop`.
- Provides the `queueEmpty` / `pop` / `insA` / `insB` consumer interface, and exerts back-pressure on fetch through `full`.

Parameters:
- DEPTH, 8, number of 32-bit instruction slots. Must be a power of two and at least 4.
- PTR_W, $clog2(DEPTH), pointer width (derived, not overridden).

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- flush  input  1  discards all entries (branch/exception redirect).
- push  input  1  fetch writes `pushInsA` this cycle.
- pushDual  input  1  when `push`=1, also writes `pushInsB` after `pushInsA`. Ignored when `push`=0.
- pushInsA  input  32  first (older) fetched instruction.
- pushInsB  input  32  second (younger) fetched instruction.
- full  output  1  fewer than 2 free slots. Fetch must not push.
- pop  input  1  decode consumes `insA` and `insB`.
- queueEmpty  output  1  fewer than 2 valid entries. No pair is available.
- insA  output  32  oldest entry (slot at head).
- insB  output  32  second-oldest entry (slot at head+1 mod DEPTH).
- count  output  PTR_W+1  current number of valid entries (debug/perf).

Behaviour:
- **Interface:**
  - One clock (`clock`). Reset (`reset`) is synchronous and active-high.
  - All state updates on the rising edge of `clock`.
- **State:**
  - Storage: DEPTH x 32.
  - Pointers: `head` and `tail`, each PTR_W bits.
  - Occupancy: `cnt`, PTR_W+1 bits.
  - Pointers wrap modulo DEPTH naturally by overflow.
- **Reset** (reset=1 at clock edge, highest priority):
  - `head`=0, `tail`=0, `cnt`=0.
  - Storage cleared to 0.
  - Outputs after reset: `queueEmpty`=1, `full`=0, `count`=0, `insA`=0, `insB`=0.
- **Flush** (reset=0, flush=1):
  - `head`=0, `tail`=0, `cnt`=0.
  - Any same-cycle push and pop are discarded.
  - Storage is not cleared.
  - Next cycle: `queueEmpty`=1, `full`=0.
- **Output decode:**
  - `queueEmpty` = (cnt < 2).
  - `full` = (cnt > DEPTH-2).
  - `insA` = mem[head].
  - `insB` = mem[head+1].
  - All combinational from registered state. No push-to-output bypass.
- **Push accepted** when push=1 and full=0:
  - mem[tail] <= pushInsA.
  - If pushDual: mem[tail+1] <= pushInsB.
  - tail advances by 1 + pushDual.
  - Push while full=1 is dropped; state is unchanged by the push.
- **Pop accepted** when pop=1 and queueEmpty=0:
  - head advances by 2.
  - Pop while queueEmpty=1 is ignored.
- **Simultaneous accepted push and pop:**
  - Both take effect.
  - cnt_next = cnt + (1 + pushDual) − 2.
  - Writes go only to free slots, so there is no read/write collision on the consumed pair.
- **Latency:**
  - A pushed instruction is visible on `insA`/`insB` the cycle after the push edge.
  - With cnt=0, a dual push makes queueEmpty=0 on the next cycle.
- **Odd occupancy:**
  - With cnt=1 (e.g. a single push after a misaligned redirect), queueEmpty stays 1 until a further push brings cnt to 2 or more.
  - The leftover entry is never lost except by flush or reset.
- **Invariants:**
  - cnt never exceeds DEPTH and never underflows.
  - tail − head ≡ cnt (mod DEPTH), except at cnt=DEPTH, where head == tail.

Decomposition:
- Shared pipeline package holds:
  - the `INS_W` = 32 constant;
  - the default queue depth constant;
  - a `fetch_pair_t` struct (insA, insB, dual) shared with the fetch stage.
- Natural single sub-module: `iq_ram`, a DEPTH x 32 register array.
  - Two write ports (wa0/wd0/we0, wa1/wd1/we1).
  - Two asynchronous read ports (ra0, ra1).
  - Synchronous clear on reset.
- Pointer/count control stays in `instruction_queue`.

Test Plan:
1. **Reset then idle:** assert reset 2 cycles -> queueEmpty=1, full=0, count=0, insA=insB=0.
2. **Dual push then pop:**
   - Push 0xAAAA0001/0xAAAA0002 with pushDual=1 -> next cycle queueEmpty=0, insA=0xAAAA0001, insB=0xAAAA0002, count=2.
   - pop=1 -> next cycle count=0, queueEmpty=1.
3. **Single pushes:**
   - Push 0x11 (pushDual=0) -> count=1, queueEmpty=1.
   - Push 0x22 -> count=2, insA=0x11, insB=0x22.
4. **Fill and wrap (DEPTH=8):**
   - Push 4 dual pairs -> count=8, full=1.
   - A fifth push is dropped.
   - Pop twice, then push 2 pairs -> tail wraps. Subsequent insA/insB are in push order; no data is lost or duplicated.
5. **Simultaneous push and pop at count=2:** dual push + pop in the same cycle -> count stays 2, insA/insB equal the newly pushed pair.
6. **Flush mid-stream:**
   - At count=6, assert flush together with push and pop -> next cycle count=0, queueEmpty=1, full=0.
   - A following push of 0x33 appears at insA after one more push.
